// File: rtl/mult_add.sv
// mult_add: single-lane signed integer ALU with fused multiply-accumulate.
//
// Each clock edge loads one result into the accumulator register, and data_o
// shows that register. In plain mode the lane adds or subtracts a_i and b_i.
// In FMA mode it either loads the product a_i*b_i (first element), or it adds
// the product to the accumulator or subtracts it from the accumulator.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_i          asynchronous active-high reset (acc = 0, overflow = 0)
//   a_i, b_i         signed operands, vdw_p bits
//   alu_op_i         0 = add, 1 = subtract
//   use_fma_i        1 = multiply-accumulate mode
//   fma_first_i      load product instead of accumulating (FMA mode only)
//   data_o           registered result / accumulator
//   flag_overflow_o  registered signed-overflow flag of the last operation
//   flag_zero_o      data_o == 0
//   flag_negative_o  sign bit of data_o
module mult_add #(
  parameter int vdw_p = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [vdw_p-1:0] a_i,
  input  logic [vdw_p-1:0] b_i,
  input  logic             alu_op_i,
  input  logic             use_fma_i,
  input  logic             fma_first_i,
  output logic [vdw_p-1:0] data_o,
  output logic             flag_overflow_o,
  output logic             flag_zero_o,
  output logic             flag_negative_o
);

  localparam int W = vdw_p;

  logic [W-1:0] acc_reg, acc_next;
  logic         ovf_reg, ovf_next;

  // Full-width signed product. Both operands are sign-extended to 2W bits,
  // so the multiply is exact.
  logic signed [2*W-1:0] a_ext, b_ext, prod_full;
  logic [W-1:0]          product;
  logic                  prod_ovf;

  assign a_ext     = {{W{a_i[W-1]}}, a_i};
  assign b_ext     = {{W{b_i[W-1]}}, b_i};
  assign prod_full = a_ext * b_ext;
  assign product   = prod_full[W-1:0];

  // The product fits in W bits only when the upper W+1 bits are all copies
  // of the sign bit.
  assign prod_ovf = ~((&prod_full[2*W-1:W-1]) | ~(|prod_full[2*W-1:W-1]));

  // Plain mode and FMA accumulate share one adder. In FMA mode the
  // accumulator takes A's place and the product takes B's place.
  logic [W-1:0] opnd_x, opnd_y, sum;
  logic         sx, sy, sr, arith_ovf;

  assign opnd_x = use_fma_i ? acc_reg : a_i;
  assign opnd_y = use_fma_i ? product : b_i;
  assign sum    = alu_op_i ? (opnd_x - opnd_y) : (opnd_x + opnd_y);

  assign sx = opnd_x[W-1];
  assign sy = opnd_y[W-1];
  assign sr = sum[W-1];

  // Add overflows when the operand signs match and the result sign differs.
  // Subtract overflows when the operand signs differ and the result sign
  // differs from the minuend.
  assign arith_ovf = alu_op_i ? ((sx != sy) && (sr != sx))
                              : ((sx == sy) && (sr != sx));

  always_comb begin
    acc_next = sum;
    ovf_next = arith_ovf;
    if (use_fma_i) begin
      if (fma_first_i) begin
        acc_next = product;
        ovf_next = prod_ovf;
      end else begin
        ovf_next = prod_ovf | arith_ovf;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      ovf_reg <= ovf_next;
    end
  end

  assign data_o          = acc_reg;
  assign flag_overflow_o = ovf_reg;
  assign flag_zero_o     = (acc_reg == '0);
  assign flag_negative_o = acc_reg[W-1];

endmodule

// File: tb/tb_mult_add.sv
// Testbench for mult_add. A stimulus process issues one operation per cycle
// and pushes the expected result into a queue. A separate monitor pops one
// entry after each rising edge and compares it with the DUT outputs.
module tb_mult_add;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] a_i, b_i;
  logic        alu_op_i, use_fma_i, fma_first_i;
  logic [31:0] data_o;
  logic        flag_overflow_o, flag_zero_o, flag_negative_o;

  mult_add #(.vdw_p(32)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .alu_op_i       (alu_op_i),
    .use_fma_i      (use_fma_i),
    .fma_first_i    (fma_first_i),
    .data_o         (data_o),
    .flag_overflow_o(flag_overflow_o),
    .flag_zero_o    (flag_zero_o),
    .flag_negative_o(flag_negative_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic        o;
    string       tag;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint m_acc  = 0;   // reference accumulator, always holds a wrapped value

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit fits32(input longint v);
    return (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
  endfunction

  function automatic longint wrap32(input longint v);
    return longint'(int'(v));
  endfunction

  // Issue one operation on the next falling edge. The reference works on
  // exact 64-bit integers. It flags overflow when the exact result falls
  // outside the 32-bit signed range, then wraps the result.
  task automatic issue(input int a, input int b, input bit op, input bit fma,
                       input bit first, input bit use_exp, input int exp_d,
                       input bit exp_o, input string tag);
    longint la, lb, p, r;
    bit     o;
    exp_t   e;
    @(negedge clk_i);
    a_i = a; b_i = b; alu_op_i = op; use_fma_i = fma; fma_first_i = first;
    la = a; lb = b;
    if (!fma) begin
      r = op ? (la - lb) : (la + lb);
      o = !fits32(r);
    end else begin
      p = la * lb;
      if (first) begin
        r = p;
        o = !fits32(p);
      end else begin
        r = op ? (m_acc - wrap32(p)) : (m_acc + wrap32(p));
        o = !fits32(p) || !fits32(r);
      end
    end
    m_acc = wrap32(r);
    if (use_exp) begin
      e.d = exp_d; e.o = exp_o;
    end else begin
      e.d = int'(m_acc); e.o = o;
    end
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 200)) - 100;
      1:       return int'($urandom);
      2:       return 32'h7FFF_FFFF - int'($urandom_range(0, 3));
      default: return 32'h8000_0000 + int'($urandom_range(0, 3));
    endcase
  endfunction

  // Monitor: compare one expected entry after every rising edge that has one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".data"}, data_o, e.d);
        chk({e.tag, ".ovf"},  flag_overflow_o, e.o);
        chk({e.tag, ".zero"}, flag_zero_o, (e.d == 32'd0));
        chk({e.tag, ".neg"},  flag_negative_o, e.d[31]);
        $display("txn %s a=%h b=%h data=%h ovf=%b", e.tag, a_i, b_i, data_o,
                 flag_overflow_o);
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    a_i = '0; b_i = '0; alu_op_i = 0; use_fma_i = 0; fma_first_i = 0;
    #2;
    chk("reset.data", data_o, 0);
    chk("reset.zero", flag_zero_o, 1);
    chk("reset.neg",  flag_negative_o, 0);
    chk("reset.ovf",  flag_overflow_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Directed cases with constant expectations
    issue(1, 3, 0, 0, 0, 1, 4, 0, "add");
    issue(10, 2, 1, 0, 0, 1, 8, 0, "sub");
    issue(5, 5, 1, 0, 0, 1, 0, 0, "sub_zero");
    issue(32'h7FFF_FFFF, 1, 0, 0, 0, 1, 32'h8000_0000, 1, "add_ovf");
    issue(32'h8000_0000, 1, 1, 0, 0, 1, 32'h7FFF_FFFF, 1, "sub_ovf");
    issue(1, 1, 0, 1, 1, 1, 1, 0, "fma1");
    issue(1, 2, 0, 1, 0, 1, 3, 0, "fma2");
    issue(1, 3, 0, 1, 0, 1, 6, 0, "fma3");
    issue(1, 4, 0, 1, 0, 1, 10, 0, "fma4");
    issue(-3, 4, 0, 1, 1, 1, -12, 0, "fma_neg");
    issue(2, 5, 1, 1, 0, 1, -22, 0, "fma_sub");
    issue(32'h10000, 32'h10000, 0, 1, 1, 1, 0, 1, "prod_ovf");
    issue(1, 1, 0, 0, 1, 1, 2, 0, "first_no_fma");

    // Reset in the middle of an FMA sequence, applied between clock edges
    issue(7, 7, 0, 1, 1, 0, 0, 0, "pre_rst1");
    issue(1, 2, 0, 1, 0, 0, 0, 0, "pre_rst2");
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrst.data", data_o, 0);
    chk("midrst.zero", flag_zero_o, 1);
    chk("midrst.neg",  flag_negative_o, 0);
    chk("midrst.ovf",  flag_overflow_o, 0);
    m_acc = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    issue(2, 3, 0, 1, 1, 1, 6, 0, "restart");
    issue(1, 4, 0, 1, 0, 1, 10, 0, "restart_acc");

    // Random operations, one per cycle with no gaps, checked against the model
    for (int i = 0; i < 300; i++) begin
      bit fma_r, first_r;
      fma_r   = $urandom_range(0, 1);
      first_r = ($urandom_range(0, 3) == 0);
      issue(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), fma_r, first_r,
            0, 0, 0, "rand");
    end

    // Drain the scoreboard, with a bound on the wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
